pgm_sprite_linebuf: RTL and testbench

PGM_SPRITE_LINEBUF -- requirements
Module: pgm_sprite_linebuf

---
 rtl/pgm_video_pkg.sv | 15 +
 rtl/pgm_linebuf_bank.sv | 29 ++
 rtl/pgm_sprite_linebuf.sv | 195 +++++++++++++++++++
 tb/tb_pgm_sprite_linebuf.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pgm_video_pkg.sv
// Shared video definitions for the sprite line buffer.
// Holds the line-buffer controller state encoding and the default
// line geometry (visible pixels per line, stored pixel width).
package pgm_video_pkg;

    localparam int LINE_W = 448;
    localparam int PIX_W  = 10;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        CLEAR  = 2'd1,
        ACCEPT = 2'd2
    } linebuf_state_e;

endpackage

// File: rtl/pgm_linebuf_bank.sv
// One line-buffer bank: simple dual-port RAM, one write port and one
// registered read port (read-before-write on a shared address).
// Ports:
//   clk            clock
//   we/waddr/wdata write port
//   raddr/rdata    read port, rdata valid the cycle after raddr
module pgm_linebuf_bank #(
    parameter int DEPTH = 448,
    parameter int WIDTH = 11,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pgm_sprite_linebuf.sv
// Double-banked sprite line buffer. Sprites are drawn into the write bank
// while the previous line is scanned out of the read bank; line_start swaps
// the banks and clears the new write bank one entry per cycle.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   line_start              swap banks (ignored during INIT)
//   wr_valid/wr_ready       pixel write handshake, wr_x/wr_pix payload
//   rd_en/rd_x              read request into the read bank
//   rd_pix/rd_hit           read result, one cycle after rd_en, held otherwise
//   bank                    current write bank index
//   busy                    high while INIT or CLEAR is running
//   drop_cnt                saturating count of writes clipped by X
module pgm_sprite_linebuf
    import pgm_video_pkg::linebuf_state_e, pgm_video_pkg::INIT,
           pgm_video_pkg::CLEAR, pgm_video_pkg::ACCEPT;
#(
    parameter int LINE_W     = pgm_video_pkg::LINE_W,
    parameter int PIX_W      = pgm_video_pkg::PIX_W,
    parameter int IDX_W      = 5,
    parameter int XW         = 11,
    parameter int PRIO_FIRST = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      line_start,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [XW-1:0]             wr_x,
    input  logic [PIX_W-1:0]          wr_pix,
    input  logic                      rd_en,
    input  logic [$clog2(LINE_W)-1:0] rd_x,
    output logic [PIX_W-1:0]          rd_pix,
    output logic                      rd_hit,
    output logic                      bank,
    output logic                      busy,
    output logic [15:0]               drop_cnt
);

    localparam int AW = $clog2(LINE_W);
    localparam int EW = PIX_W + 1;   // {written flag, pixel}
    localparam logic [AW-1:0] LAST_ENTRY = AW'(LINE_W - 1);

    linebuf_state_e  state_reg, state_next;
    logic [AW-1:0]   clr_reg, clr_next;
    logic            bank_reg, bank_next;
    logic [15:0]     drop_reg;

    // Write pipeline: stage 1 holds an accepted opaque write while the
    // target flag is fetched from the write bank's read port.
    logic            s1_valid_reg, s1_bank_reg;
    logic [AW-1:0]   s1_x_reg;
    logic [PIX_W-1:0] s1_pix_reg;
    // Forwarding of the write committed in the previous cycle; its RAM
    // update is not yet visible to a lookup issued in that same cycle.
    logic            lc_valid_reg, lc_bank_reg;
    logic [AW-1:0]   lc_x_reg;

    logic            rd_valid_reg, rd_sel_reg, rd_zero_reg;
    logic [EW-1:0]   rd_hold_reg, rd_fresh;

    logic            accept, wr_in_range, wr_opaque, s1_flag, s1_commit;
    logic [AW-1:0]   wr_addr, rd_addr;

    logic            bank_we    [2];
    logic [AW-1:0]   bank_waddr [2];
    logic [AW-1:0]   bank_raddr [2];
    logic [EW-1:0]   bank_wdata [2];
    logic [EW-1:0]   bank_rdata [2];

    // ---------------- controller ----------------
    always_comb begin
        state_next = state_reg;
        clr_next   = clr_reg;
        bank_next  = bank_reg;
        case (state_reg)
            INIT: begin
                if (clr_reg == LAST_ENTRY) begin
                    state_next = ACCEPT;
                    clr_next   = '0;
                end else begin
                    clr_next = clr_reg + 1'b1;
                end
            end
            CLEAR: begin
                if (line_start) begin
                    bank_next = ~bank_reg;
                    clr_next  = '0;
                end else if (clr_reg == LAST_ENTRY) begin
                    state_next = ACCEPT;
                    clr_next   = '0;
                end else begin
                    clr_next = clr_reg + 1'b1;
                end
            end
            ACCEPT: begin
                if (line_start) begin
                    state_next = CLEAR;
                    bank_next  = ~bank_reg;
                    clr_next   = '0;
                end
            end
            default: begin
                state_next = INIT;
                clr_next   = '0;
            end
        endcase
    end

    assign busy     = (state_reg != ACCEPT);
    assign wr_ready = (state_reg == ACCEPT) && !line_start;
    assign bank     = bank_reg;
    assign drop_cnt = drop_reg;

    // ---------------- write path ----------------
    assign accept      = wr_valid && wr_ready;
    assign wr_in_range = (wr_x < XW'(LINE_W));
    assign wr_opaque   = |wr_pix[IDX_W-1:0];
    assign wr_addr     = wr_in_range ? wr_x[AW-1:0] : '0;
    assign rd_addr     = (rd_x < AW'(LINE_W)) ? rd_x : '0;

    assign s1_flag   = bank_rdata[s1_bank_reg][PIX_W]
                     | (lc_valid_reg && (lc_bank_reg == s1_bank_reg) && (lc_x_reg == s1_x_reg));
    assign s1_commit = s1_valid_reg && !reset && ((PRIO_FIRST == 0) || !s1_flag);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= INIT;
            clr_reg      <= '0;
            bank_reg     <= 1'b0;
            drop_reg     <= '0;
            s1_valid_reg <= 1'b0;
            lc_valid_reg <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_hold_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            clr_reg      <= clr_next;
            bank_reg     <= bank_next;
            s1_valid_reg <= accept && wr_in_range && wr_opaque;
            lc_valid_reg <= s1_commit;
            rd_valid_reg <= rd_en;
            if (accept && !wr_in_range && (drop_reg != 16'hFFFF)) begin
                drop_reg <= drop_reg + 16'd1;
            end
            if (rd_valid_reg) begin
                rd_hold_reg <= rd_fresh;
            end
        end
    end

    always_ff @(posedge clk) begin
        s1_bank_reg <= bank_reg;
        s1_x_reg    <= wr_addr;
        s1_pix_reg  <= wr_pix;
        lc_bank_reg <= s1_bank_reg;
        lc_x_reg    <= s1_x_reg;
        rd_sel_reg  <= ~bank_reg;
        rd_zero_reg <= (state_reg == INIT) || (rd_x >= AW'(LINE_W));
    end

    // ---------------- banks ----------------
    // The write bank's read port serves the flag lookup; the read bank's
    // read port serves external reads.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic clear_here, commit_here;
            assign clear_here  = (state_reg == INIT)
                              || ((state_reg == CLEAR) && (bank_reg == 1'(gi)));
            assign commit_here = s1_commit && (s1_bank_reg == 1'(gi));
            assign bank_we[gi]    = clear_here || commit_here;
            assign bank_waddr[gi] = clear_here ? clr_reg : s1_x_reg;
            assign bank_wdata[gi] = clear_here ? '0 : {1'b1, s1_pix_reg};
            assign bank_raddr[gi] = (bank_reg == 1'(gi)) ? wr_addr : rd_addr;

            pgm_linebuf_bank #(
                .DEPTH (LINE_W),
                .WIDTH (EW)
            ) u_bank (
                .clk   (clk),
                .we    (bank_we[gi]),
                .waddr (bank_waddr[gi]),
                .wdata (bank_wdata[gi]),
                .raddr (bank_raddr[gi]),
                .rdata (bank_rdata[gi])
            );
        end
    endgenerate

    // ---------------- read result ----------------
    assign rd_fresh = rd_zero_reg ? '0 : bank_rdata[rd_sel_reg];
    assign rd_pix   = rd_valid_reg ? rd_fresh[PIX_W-1:0] : rd_hold_reg[PIX_W-1:0];
    assign rd_hit   = rd_valid_reg ? rd_fresh[PIX_W]     : rd_hold_reg[PIX_W];

endmodule

// File: tb/tb_pgm_sprite_linebuf.sv
// Self-checking bench for pgm_sprite_linebuf. Two instances share all
// inputs: one with first-write-wins priority, one with last-write-wins.
// A behavioural model applies each accepted write immediately and clears
// a whole bank at once on a swap.
module tb_pgm_sprite_linebuf;

    localparam int LW = 448;

    logic        clk = 1'b0;
    logic        reset, line_start, wr_valid, rd_en;
    logic [10:0] wr_x;
    logic [9:0]  wr_pix;
    logic [8:0]  rd_x;

    logic        wr_ready_p1, rd_hit_p1, bank_p1, busy_p1;
    logic [9:0]  rd_pix_p1;
    logic [15:0] drop_p1;
    logic        wr_ready_p0, rd_hit_p0, bank_p0, busy_p0;
    logic [9:0]  rd_pix_p0;
    logic [15:0] drop_p0;

    always #5 clk = ~clk;

    pgm_sprite_linebuf #(.PRIO_FIRST(1)) dut_p1 (
        .clk(clk), .reset(reset), .line_start(line_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready_p1), .wr_x(wr_x), .wr_pix(wr_pix),
        .rd_en(rd_en), .rd_x(rd_x), .rd_pix(rd_pix_p1), .rd_hit(rd_hit_p1),
        .bank(bank_p1), .busy(busy_p1), .drop_cnt(drop_p1)
    );

    pgm_sprite_linebuf #(.PRIO_FIRST(0)) dut_p0 (
        .clk(clk), .reset(reset), .line_start(line_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready_p0), .wr_x(wr_x), .wr_pix(wr_pix),
        .rd_en(rd_en), .rd_x(rd_x), .rd_pix(rd_pix_p0), .rd_hit(rd_hit_p0),
        .bank(bank_p0), .busy(busy_p0), .drop_cnt(drop_p0)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // model state: [priority 0/1][bank][x] = {written, pixel}
    logic [10:0] ref_mem [2][2][LW];
    logic        ref_bank;
    int          ref_busy;
    bit          ref_init;
    logic [15:0] ref_drop;
    logic [10:0] ref_rd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int b);
        for (int p = 0; p < 2; p++)
            for (int x = 0; x < LW; x++)
                ref_mem[p][b][x] = '0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_clear(0);
            model_clear(1);
            ref_bank = 1'b0;
            ref_busy = LW;
            ref_init = 1'b1;
            ref_drop = '0;
            ref_rd[0] = '0;
            ref_rd[1] = '0;
        end else begin
            if (rd_en) begin
                for (int p = 0; p < 2; p++) begin
                    if (ref_init || rd_x >= LW) ref_rd[p] = '0;
                    else ref_rd[p] = ref_mem[p][ref_bank ^ 1'b1][rd_x];
                end
            end
            if (ref_busy == 0 && wr_valid && !line_start) begin
                if (wr_x >= LW) begin
                    if (ref_drop != 16'hFFFF) ref_drop = ref_drop + 16'd1;
                end else if (wr_pix[4:0] != 5'd0) begin
                    for (int p = 0; p < 2; p++)
                        if (!(p == 1 && ref_mem[p][ref_bank][wr_x][10]))
                            ref_mem[p][ref_bank][wr_x] = {1'b1, wr_pix};
                end
            end
            if (line_start && !ref_init) begin
                ref_bank = ref_bank ^ 1'b1;
                model_clear(int'(ref_bank));
                ref_busy = LW;
            end else if (ref_busy > 0) begin
                ref_busy--;
                if (ref_busy == 0) ref_init = 1'b0;
            end
        end
    endtask

    task automatic check_regs();
        chk("busy_p1", busy_p1, ref_busy != 0);
        chk("busy_p0", busy_p0, ref_busy != 0);
        chk("bank_p1", bank_p1, ref_bank);
        chk("bank_p0", bank_p0, ref_bank);
        chk("drop_p1", drop_p1, ref_drop);
        chk("drop_p0", drop_p0, ref_drop);
        chk("rd_pix_p1", rd_pix_p1, ref_rd[1][9:0]);
        chk("rd_hit_p1", rd_hit_p1, ref_rd[1][10]);
        chk("rd_pix_p0", rd_pix_p0, ref_rd[0][9:0]);
        chk("rd_hit_p0", rd_hit_p0, ref_rd[0][10]);
    endtask

    // inputs are driven at the falling edge before calling tick
    task automatic tick();
        #1;
        chk("wr_ready_p1", wr_ready_p1, (ref_busy == 0) && !line_start);
        chk("wr_ready_p0", wr_ready_p0, (ref_busy == 0) && !line_start);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_regs();
    endtask

    task automatic tick_quiet();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int want);
        int cnt;
        cnt = 0;
        while (busy_p1 === 1'b1 && cnt < 2000) begin
            tick();
            cnt++;
        end
        chk(tag, cnt, want);
    endtask

    task automatic read_at(input int x);
        rd_en = 1'b1;
        rd_x  = 9'(x);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic write_px(input int x, input logic [9:0] pix);
        wr_valid = 1'b1;
        wr_x     = 11'(x);
        wr_pix   = pix;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic swap();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        wait_idle("clear_len", LW);
    endtask

    logic [15:0] drop_saved;

    initial begin
        reset = 1'b1; line_start = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
        wr_x = '0; wr_pix = '0; rd_x = '0;
        @(negedge clk);
        tick_quiet();
        tick();
        reset = 1'b0;

        // power-up INIT length and empty banks
        wait_idle("init_len", LW);
        for (int x = 0; x < LW; x += 37) read_at(x);
        read_at(447);
        read_at(500);
        chk("init_rd_hit", rd_hit_p1, 1'b0);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        for (int i = 0; i < 200; i++) read_at(i * 2);
        wait_idle("first_clear_len", LW - 200);

        // priority on back-to-back same-X writes
        wr_valid = 1'b1; wr_x = 11'd10; wr_pix = 10'h0A3; tick();
        wr_pix = 10'h1F1; tick();
        wr_valid = 1'b0;
        swap();
        read_at(10);
        chk("prio_first_pix", rd_pix_p1, 10'h0A3);
        chk("prio_first_hit", rd_hit_p1, 1'b1);
        chk("prio_last_pix", rd_pix_p0, 10'h1F1);
        chk("rd_hold", rd_pix_p1, 10'h0A3);
        tick();
        chk("rd_hold_after", rd_pix_p1, 10'h0A3);

        // transparent pixel
        drop_saved = drop_p1;
        write_px(5, 10'h3E0);
        swap();
        read_at(5);
        chk("transp_hit", rd_hit_p1, 1'b0);
        chk("transp_drop", drop_p1, drop_saved);

        // clipping and saturation
        write_px(448, 10'h011);
        write_px(500, 10'h012);
        write_px(2047, 10'h013);
        chk("drop_three", drop_p1, 16'd3);
        wr_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            wr_x   = 11'($urandom_range(448, 2047));
            wr_pix = 10'($urandom_range(1, 1023));
            tick_quiet();
        end
        wr_valid = 1'b0;
        tick();
        chk("drop_sat", drop_p1, 16'hFFFF);
        swap();
        for (int x = 440; x < LW; x++) read_at(x);

        // write held across line_start is refused
        wr_valid = 1'b1; wr_x = 11'd20; wr_pix = 10'h055; line_start = 1'b1;
        tick();
        line_start = 1'b0;
        wait_idle("ls_busy_len", LW);
        wr_valid = 1'b0;
        read_at(20);
        chk("ls_nowrite_a", rd_hit_p1, 1'b0);
        swap();
        read_at(20);
        chk("ls_nowrite_b", rd_hit_p1, 1'b0);

        // randomized lines
        for (int ln = 0; ln < 6; ln++) begin
            for (int c = 0; c < 250; c++) begin
                wr_valid = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) wr_x = 11'($urandom_range(0, 600));
                else wr_x = 11'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) wr_pix = 10'($urandom_range(0, 31) << 5);
                else wr_pix = 10'($urandom);
                rd_en = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) rd_x = 9'($urandom);
                else rd_x = 9'($urandom_range(0, 15));
                line_start = ($urandom_range(0, 199) == 0);
                tick();
            end
            wr_valid = 1'b0; rd_en = 1'b0;
            line_start = 1'b1;
            tick();
            line_start = 1'b0;
            while (busy_p1 === 1'b1) begin
                rd_en = 1'($urandom_range(0, 1));
                rd_x  = 9'($urandom_range(0, 15));
                tick();
            end
            rd_en = 1'b0;
            for (int x = 0; x < 16; x++) read_at(x);
        end

        // reset in the middle of a clear
        write_px(30, 10'h0AB);
        swap();
        write_px(31, 10'h0CD);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        for (int i = 0; i < 200; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_idle("rst_init_len", LW);
        chk("rst_bank", bank_p1, 1'b0);
        read_at(30);
        chk("rst_rd30_a", rd_hit_p1, 1'b0);
        read_at(31);
        chk("rst_rd31_a", rd_hit_p1, 1'b0);
        swap();
        read_at(30);
        chk("rst_rd30_b", rd_pix_p0, 10'h000);
        read_at(31);
        chk("rst_rd31_b", rd_hit_p0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
